// File: rtl/datamem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the data-memory arbiter.
// Optional performance counter is enabled with macro DATAMEM_ARB_PERF_EN.
// Widths fall back to local defaults when the project-wide macros are absent.

`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 8
`endif
`ifndef DATAMEM_ARB_N_REQ
`define DATAMEM_ARB_N_REQ 4
`endif
`ifndef DATAMEM_ARB_IDLE
`define DATAMEM_ARB_IDLE 1'b0
`endif
`ifndef DATAMEM_ARB_ACCESS
`define DATAMEM_ARB_ACCESS 1'b1
`endif

package datamem_arbiter_pkg;

    localparam int DATAMEM_ARB_N_REQ_DEF = `DATAMEM_ARB_N_REQ;

    typedef enum logic {
        ARB_IDLE   = `DATAMEM_ARB_IDLE,
        ARB_ACCESS = `DATAMEM_ARB_ACCESS
    } arb_state_t;

`ifdef DATAMEM_ARB_PERF_EN
    localparam logic [15:0] PERF_CNT_MAX = 16'hFFFF;

    // Population count of an up-to-8-bit request mask.
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/datamem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of the
// eligible mask starting at ptr and wrapping through N-1 to 0.
// Shared with the instruction-memory arbiter.

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the farthest slot back to ptr so the closest hit wins.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (eligible[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between N_REQ
// requesters. One transaction per grant: IDLE picks, ACCESS drives memory,
// the following IDLE cycle carries a one-cycle ack and registered rdata.
// Defining DATAMEM_ARB_PERF_EN adds the conflict_cnt output.

module datamem_arbiter
    import datamem_arbiter_pkg::*;
#(
    parameter int N_REQ = DATAMEM_ARB_N_REQ_DEF,
    parameter int AW    = `DATAMEM_ADDR_WIDTH,
    parameter int DW    = `DATA_WORD_LENGTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
`ifdef DATAMEM_ARB_PERF_EN
    ,
    output logic [15:0]         conflict_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t        state_r, state_n;
    logic [IW-1:0]     rr_ptr_r, rr_ptr_n;
    logic [IW-1:0]     grant_r, grant_n;
    logic [N_REQ-1:0]  ack_r, ack_n;
    logic [DW-1:0]     rdata_r, rdata_n;
    logic              mem_we_r, mem_we_n;
    logic [AW-1:0]     mem_addr_r, mem_addr_n;
    logic [DW-1:0]     mem_wdata_r, mem_wdata_n;

    logic [N_REQ-1:0]  eligible_s;
    logic              pick_valid_s;
    logic [IW-1:0]     pick_idx_s;

    // A requester is masked during its own ack cycle so a held req is not re-granted.
    assign eligible_s = req & ~ack_r;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (rr_ptr_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Next-state and next-output logic for the IDLE/ACCESS sequencer.
    always_comb begin
        state_n     = state_r;
        rr_ptr_n    = rr_ptr_r;
        grant_n     = grant_r;
        ack_n       = '0;
        rdata_n     = rdata_r;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    grant_n     = pick_idx_s;
                    mem_we_n    = we[pick_idx_s];
                    mem_addr_n  = addr[int'(pick_idx_s) * AW +: AW];
                    mem_wdata_n = wdata[int'(pick_idx_s) * DW +: DW];
                    state_n     = ARB_ACCESS;
                end else begin
                    state_n = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (mem_we_r) begin
                    rdata_n = rdata_r;
                end else begin
                    rdata_n = mem_rdata;
                end
                ack_n[grant_r] = 1'b1;
                if (grant_r == IW'(N_REQ - 1)) begin
                    rr_ptr_n = '0;
                end else begin
                    rr_ptr_n = grant_r + IW'(1);
                end
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // State and registered-output flops; async reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            ack_r       <= '0;
            rdata_r     <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= state_n;
            rr_ptr_r    <= rr_ptr_n;
            grant_r     <= grant_n;
            ack_r       <= ack_n;
            rdata_r     <= rdata_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

`ifdef DATAMEM_ARB_PERF_EN
    logic [15:0] conflict_cnt_r, conflict_cnt_n;

    // Count IDLE cycles with contention, saturating at the maximum.
    always_comb begin
        conflict_cnt_n = conflict_cnt_r;
        if ((state_r == ARB_IDLE) && (count_ones(8'(eligible_s)) > 4'd1)
            && (conflict_cnt_r != PERF_CNT_MAX)) begin
            conflict_cnt_n = conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_n = conflict_cnt_r;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_r <= 16'd0;
        end else begin
            conflict_cnt_r <= conflict_cnt_n;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
